neg_edge_serial_deserializer: RTL and testbench

- Serial-to-parallel capture stage that packs a clocked serial bit stream into WIDTH-bit words.
- Every state element is negative-edge triggered D storage with asynchronous active-high clear.
- Sits downstream of the single-bit D flip-flop cells and consumes their serial output.
- Delivers parallel words plus a one-cycle completion strobe to the word-level logic.

---
 rtl/neg_edge_serial_deserializer_if.sv | 31 +++
 rtl/neg_edge_serial_deserializer.sv | 109 ++++++++++
 tb/tb_neg_edge_serial_deserializer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/neg_edge_serial_deserializer_if.sv
// Serial-in / parallel-out bundle between the serial bit source and the
// deserializer. The master drives the serial side, the slave (deserializer)
// returns the packed word, the completion strobe and the busy flag.
interface neg_edge_serial_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             shift_en;
    logic             sync;
    logic [WIDTH-1:0] pout;
    logic             done;
    logic             busy;

    modport master (
        output sin,
        output shift_en,
        output sync,
        input  pout,
        input  done,
        input  busy
    );

    modport slave (
        input  sin,
        input  shift_en,
        input  sync,
        output pout,
        output done,
        output busy
    );
endinterface

// File: rtl/neg_edge_serial_deserializer.sv
// Negative-edge serial-to-parallel capture stage. Bits arrive MSB first,
// are qualified by shift_en and packed into WIDTH-bit words. A completed
// word is published on pout together with a one-period done strobe; sync
// abandons the partial word and restarts framing. All storage is cleared
// asynchronously by clear and only ever changes on the falling clock edge.
module neg_edge_serial_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 clear,
    neg_edge_serial_deserializer_if.slave        bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] pout_reg;
    logic [WIDTH-1:0] pout_next;
    logic             done_reg;
    logic             done_next;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] fresh;

    // Candidate register contents for an accepted bit: appended to the
    // current word, or starting a brand new word after a restart.
    assign shifted = {shreg[WIDTH-2:0], bus.sin};
    assign fresh   = {{(WIDTH-1){1'b0}}, bus.sin};

    // Falling-edge storage for every state element, cleared asynchronously.
    always_ff @(negedge clk or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            pout_reg <= '0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            cnt      <= cnt_next;
            pout_reg <= pout_next;
            done_reg <= done_next;
        end
    end

    // Framing decisions: accept, stall, complete or restart the current word.
    // sin is only looked at on paths where shift_en is high.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        pout_next  = pout_reg;
        done_next  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.shift_en) begin
                    shreg_next = fresh;
                    cnt_next   = ONE_CNT;
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                if (bus.sync) begin
                    if (bus.shift_en) begin
                        shreg_next = fresh;
                        cnt_next   = ONE_CNT;
                    end else begin
                        shreg_next = '0;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end else if (bus.shift_en) begin
                    shreg_next = shifted;
                    if (cnt == LAST_CNT) begin
                        pout_next  = shifted;
                        done_next  = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + ONE_CNT;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.pout = pout_reg;
    assign bus.done = done_reg;
    assign bus.busy = (state == SHIFT);

endmodule

// File: tb/tb_neg_edge_serial_deserializer.sv
// Self-checking bench for the negative-edge deserializer. A driver issues
// directed and random serial traffic and, for each falling edge it drives,
// pushes the expected outcome produced by a bit-list reference model; a
// separate monitor pops those expectations and compares the DUT outputs
// just after the falling edge and again just after the following rising
// edge. Completed words are additionally matched from a word queue
// whenever the DUT raises done.
module tb_neg_edge_serial_deserializer;

    localparam int WIDTH = 4;

    typedef struct {
        logic             done;
        logic             busy;
        logic [WIDTH-1:0] pout;
    } expect_t;

    logic clk;
    logic clear;

    neg_edge_serial_deserializer_if #(.WIDTH(WIDTH)) bus ();

    neg_edge_serial_deserializer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    int checkCount = 0;
    int errorCount = 0;

    expect_t          edgeQ[$];
    logic [WIDTH-1:0] wordQ[$];
    bit               partialQ[$];
    logic [WIDTH-1:0] lastWord = '0;

    // Free-running clock; falling edges are the active ones.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute guard so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: act=timeout req=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
        checkCount++;
        if (act !== req) begin
            errorCount++;
            $display("[TB] FAIL %s: act=%0h req=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input expect_t e);
        compare({tag, "_done"}, 32'(bus.done), 32'(e.done));
        compare({tag, "_busy"}, 32'(bus.busy), 32'(e.busy));
        compare({tag, "_pout"}, 32'(bus.pout), 32'(e.pout));
    endtask

    // Reference model: the partial word is a plain list of received bits.
    function automatic expect_t modelEdge(input bit se, input bit sy, input bit s);
        expect_t          e;
        logic [WIDTH-1:0] w;
        e.done = 1'b0;
        if (sy) begin
            partialQ.delete();
            if (se) partialQ.push_back(s);
        end else if (se) begin
            partialQ.push_back(s);
            if (partialQ.size() == WIDTH) begin
                w = '0;
                foreach (partialQ[i]) w = {w[WIDTH-2:0], partialQ[i]};
                wordQ.push_back(w);
                lastWord = w;
                e.done   = 1'b1;
                partialQ.delete();
            end
        end
        e.busy = (partialQ.size() != 0);
        e.pout = lastWord;
        return e;
    endfunction

    // Drive one falling edge worth of inputs. With decoy set, unrelated
    // values sit on the inputs across the rising edge and are replaced
    // before the falling edge that samples them.
    task automatic applyStimulus(input bit se, input bit sy, input bit s, input bit decoy);
        if (decoy) begin
            #1;
            bus.shift_en = 1'($urandom);
            bus.sync     = 1'($urandom);
            bus.sin      = 1'($urandom);
        end
        @(posedge clk);
        #2;
        bus.shift_en = se;
        bus.sync     = sy;
        bus.sin      = (se || sy) ? s : 1'bx;
        edgeQ.push_back(modelEdge(se, sy, s));
        @(negedge clk);
    endtask

    task automatic applyBits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, 1'b0, bits[i], 1'b0);
    endtask

    // Asynchronous clear between edges, checked immediately, then released.
    task automatic applyClear();
        @(posedge clk);
        #2;
        bus.shift_en = 1'b0;
        bus.sync     = 1'b0;
        clear        = 1'b1;
        #1;
        compare("clear_pout", 32'(bus.pout), 32'(0));
        compare("clear_busy", 32'(bus.busy), 32'(0));
        compare("clear_done", 32'(bus.done), 32'(0));
        partialQ.delete();
        lastWord = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Monitor: scoreboard side, fully decoupled from the driver.
    initial begin
        expect_t          cur;
        bit               have;
        logic [WIDTH-1:0] w;
        have = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (edgeQ.size() > 0) begin
                cur  = edgeQ.pop_front();
                have = 1'b1;
                checkOutput("neg", cur);
                if (bus.done === 1'b1) begin
                    if (wordQ.size() == 0) begin
                        compare("word_unexpected", 32'(1), 32'(0));
                    end else begin
                        w = wordQ.pop_front();
                        compare("word", 32'(bus.pout), 32'(w));
                    end
                end
            end else begin
                have = 1'b0;
            end
            @(posedge clk);
            #1;
            if (have) checkOutput("pos", cur);
        end
    end

    initial begin
        bit se;
        bit sy;
        bit s;
        bit dc;
        bus.sin      = 1'b0;
        bus.shift_en = 1'b0;
        bus.sync     = 1'b0;
        clear        = 1'b1;
        #3;
        compare("reset_pout", 32'(bus.pout), 32'(0));
        compare("reset_busy", 32'(bus.busy), 32'(0));
        compare("reset_done", 32'(bus.done), 32'(0));
        @(posedge clk);
        #1;
        clear = 1'b0;

        $display("[TB] async clear mid-word");
        applyBits(32'b101, 3);
        applyClear();
        applyBits(32'b0011, 4);

        $display("[TB] basic word");
        applyBits(32'b1011, 4);

        $display("[TB] stall");
        applyBits(32'b11, 2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'(i), 1'b0);
        applyBits(32'b01, 2);

        $display("[TB] back-to-back");
        applyBits(32'b10010110, 8);

        $display("[TB] sync restart");
        applyBits(32'b111, 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyBits(32'b101, 3);
        applyBits(32'b110, 3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] edge polarity");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            se = ($urandom_range(0, 3) != 0);
            sy = ($urandom_range(0, 11) == 0);
            s  = 1'($urandom);
            dc = ($urandom_range(0, 4) == 0);
            applyStimulus(se, sy, s, dc);
            if ((i % 150) == 149) applyClear();
        end

        bus.shift_en = 1'b0;
        bus.sync     = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        compare("words_left", 32'(wordQ.size()), 32'(0));
        compare("edges_left", 32'(edgeQ.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
